riscv_mem_arb: RTL

- Arbiter and sequencer that shares one single-port word memory between the RISC-V core's instruction-fetch port and its load/store port.
- Used by the multi-cycle/unified-memory core variant, where fetch and data access cannot both hit memory in the same cycle.
- Grants one requester at a time, drives the memory for a fixed latency, and returns read data with a one-cycle ready pulse.
- Data port has priority; a streak limit prevents fetch starvation.

---
 rtl/riscv_mem_arb.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/riscv_mem_arb.sv
// Single-port memory arbiter/sequencer shared by instruction fetch and load/store.
// Optional statistics counters are enabled with `define RISCV_MEM_ARB_STATS_EN.
module riscv_mem_arb #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MEM_LAT      = 1,
  parameter int MAX_D_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
`ifdef RISCV_MEM_ARB_STATS_EN
  ,
  output logic [31:0]   stat_i_grants,
  output logic [31:0]   stat_d_grants,
  output logic [31:0]   stat_conflicts
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_DONE
  } state_e;

  localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT);
  localparam logic [3:0] MAX_STREAK = 4'(MAX_D_STREAK);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    d_streak_q, d_streak_d;
  logic          is_data_q, is_data_d;
  logic          m_en_q, m_en_d;
  logic          m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          i_ready_q, i_ready_d;
  logic          d_ready_q, d_ready_d;
  logic          busy_q, busy_d;

  logic          grant_any;
  logic          grant_data;

  // Data wins unless fetch is also waiting and the data streak is exhausted.
  assign grant_any  = i_req | d_req;
  assign grant_data = d_req & (~i_req | (d_streak_q < MAX_STREAK));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    d_streak_d = d_streak_q;
    is_data_d  = is_data_q;
    m_en_d     = 1'b0;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    i_ready_d  = 1'b0;
    d_ready_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          state_d   = S_ACCESS;
          m_en_d    = 1'b1;
          cnt_d     = LAT_INIT;
          is_data_d = grant_data;
          if (grant_data) begin
            m_we_d     = d_we;
            m_addr_d   = d_addr;
            m_wdata_d  = d_wdata;
            d_streak_d = i_req ? d_streak_q + 4'd1 : 4'd0;
          end else begin
            m_we_d     = 1'b0;
            m_addr_d   = i_addr;
            m_wdata_d  = '0;
            d_streak_d = 4'd0;
          end
        end
      end
      S_ACCESS: state_d = S_WAIT;
      S_WAIT: begin
        // cnt==1 marks the cycle in which m_rdata is valid.
        if (cnt_q == 4'd1) begin
          state_d = S_DONE;
          if (is_data_q) begin
            d_ready_d = 1'b1;
            if (!m_we_q) d_rdata_d = m_rdata;
          end else begin
            i_ready_d = 1'b1;
            i_rdata_d = m_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      d_streak_q <= '0;
      is_data_q  <= 1'b0;
      m_en_q     <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      i_ready_q  <= 1'b0;
      d_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      d_streak_q <= d_streak_d;
      is_data_q  <= is_data_d;
      m_en_q     <= m_en_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      i_ready_q  <= i_ready_d;
      d_ready_q  <= d_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign i_rdata = i_rdata_q;
  assign i_ready = i_ready_q;
  assign d_rdata = d_rdata_q;
  assign d_ready = d_ready_q;
  assign m_en    = m_en_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign busy    = busy_q;

`ifdef RISCV_MEM_ARB_STATS_EN
  logic [31:0] stat_i_q, stat_d_q, stat_c_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_i_q <= '0;
      stat_d_q <= '0;
      stat_c_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (grant_any && grant_data)  stat_d_q <= stat_d_q + 32'd1;
      if (grant_any && !grant_data) stat_i_q <= stat_i_q + 32'd1;
      if (i_req && d_req)           stat_c_q <= stat_c_q + 32'd1;
    end
  end

  assign stat_i_grants  = stat_i_q;
  assign stat_d_grants  = stat_d_q;
  assign stat_conflicts = stat_c_q;
`endif

endmodule
